// File: rtl/obi_buf_pkg.sv
// Shared types for the OBI posted-write buffer: master FSM states and the
// write-buffer entry layout at the default bus widths.
package obi_buf_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 32;
  localparam int unsigned WB_DATA_WIDTH = 32;
  localparam int unsigned WB_BE_WIDTH   = WB_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    M_IDLE    = 2'd0,
    M_WR_WAIT = 2'd1,
    M_RD_REQ  = 2'd2,
    M_RD_WAIT = 2'd3
  } m_state_e;

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_BE_WIDTH-1:0]   be;
    logic [WB_DATA_WIDTH-1:0] wdata;
  } wbuf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth; head entry is visible
// combinationally whenever the FIFO is non-empty.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type entry_t = obi_buf_pkg::wbuf_entry_t,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  entry_t           push_data,
  input  logic             pop,
  output entry_t           head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             push_en;
  logic             pop_en;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap modulo DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_en && !pop_en) begin
        count_q <= count_q + 1'b1;
      end else if (pop_en && !push_en) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/obi_write_buffer.sv
// Posted-write buffer between a cache's OBI master port and memory. Writes are
// acknowledged on entry to the FIFO; reads go downstream only once it drains.
//
// Handshake: a request transfers on the cycle where req and gnt are both high;
// the requester holds req and its payload stable until gnt. Each granted
// request gets exactly one rvalid, never in the grant cycle itself, and at
// most one downstream transaction is outstanding at any time.
module obi_write_buffer
  import obi_buf_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    s_req_i,
  output logic                    s_gnt_o,
  input  logic                    s_we_i,
  input  logic [DATA_WIDTH/8-1:0] s_be_i,
  input  logic [ADDR_WIDTH-1:0]   s_addr_i,
  input  logic [DATA_WIDTH-1:0]   s_wdata_i,
  output logic [DATA_WIDTH-1:0]   s_rdata_o,
  output logic                    s_rvalid_o,
  output logic                    m_req_o,
  input  logic                    m_gnt_i,
  output logic                    m_we_o,
  output logic [DATA_WIDTH/8-1:0] m_be_o,
  output logic [ADDR_WIDTH-1:0]   m_addr_o,
  output logic [DATA_WIDTH-1:0]   m_wdata_o,
  input  logic [DATA_WIDTH-1:0]   m_rdata_i,
  input  logic                    m_rvalid_i,
  output logic                    empty_o
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] wdata;
  } entry_t;

  m_state_e              state_q;
  m_state_e              state_d;
  logic                  wr_rsp_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  entry_t                push_entry;
  entry_t                head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;

  logic                  rd_pending;
  logic                  wr_gnt;
  logic                  rd_gnt;
  logic                  pop;
  logic                  rd_rsp;

  assign push_entry = '{addr: s_addr_i, be: s_be_i, wdata: s_wdata_i};

  sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_wr_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .push      (wr_gnt),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Writes are blocked while a read is in progress so the read's response
  // cannot collide with a posted-write acknowledge.
  assign rd_pending = (state_q == M_RD_REQ) || (state_q == M_RD_WAIT);
  assign wr_gnt = !rst_i && s_req_i && s_we_i && !fifo_full && !rd_pending;
  assign rd_gnt = !rst_i && s_req_i && !s_we_i && (state_q == M_IDLE)
                  && fifo_empty && !wr_rsp_q;
  assign pop    = !rst_i && (state_q == M_IDLE) && !fifo_empty && m_gnt_i;
  assign rd_rsp = !rst_i && (state_q == M_RD_WAIT) && m_rvalid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= M_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      M_IDLE: begin
        if (!fifo_empty) begin
          if (m_gnt_i) state_d = M_WR_WAIT;
        end else if (rd_gnt) begin
          state_d = M_RD_REQ;
        end
      end
      M_WR_WAIT: if (m_rvalid_i) state_d = M_IDLE;
      M_RD_REQ:  if (m_gnt_i)    state_d = M_RD_WAIT;
      M_RD_WAIT: if (m_rvalid_i) state_d = M_IDLE;
      default:   state_d = M_IDLE;
    endcase
  end

  always_comb begin
    m_req_o   = 1'b0;
    m_we_o    = 1'b0;
    m_be_o    = '0;
    m_addr_o  = '0;
    m_wdata_o = '0;
    if (!rst_i) begin
      case (state_q)
        M_IDLE: begin
          if (!fifo_empty) begin
            m_req_o   = 1'b1;
            m_we_o    = 1'b1;
            m_be_o    = head.be;
            m_addr_o  = head.addr;
            m_wdata_o = head.wdata;
          end
        end
        M_RD_REQ: begin
          m_req_o  = 1'b1;
          m_be_o   = '1;
          m_addr_o = rd_addr_q;
        end
        default: ;
      endcase
    end
    s_gnt_o    = wr_gnt || rd_gnt;
    s_rvalid_o = (wr_rsp_q && !rst_i) || rd_rsp;
    s_rdata_o  = rd_rsp ? m_rdata_i : '0;
    empty_o    = rst_i || ((fifo_count == '0) && (state_q == M_IDLE));
  end

  // Posted writes are acknowledged one cycle after their grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_rsp_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      wr_rsp_q <= wr_gnt;
      if (rd_gnt) rd_addr_q <= s_addr_i;
    end
  end

endmodule

// File: tb/tb_obi_write_buffer.sv
// Bench for obi_write_buffer: upstream driver, memory responder with tunable
// grant/response latency, and scoreboards for downstream and upstream traffic.
module tb_obi_write_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int BW    = DW / 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          s_req_i = 1'b0;
  logic          s_gnt_o;
  logic          s_we_i = 1'b0;
  logic [BW-1:0] s_be_i = '0;
  logic [AW-1:0] s_addr_i = '0;
  logic [DW-1:0] s_wdata_i = '0;
  logic [DW-1:0] s_rdata_o;
  logic          s_rvalid_o;
  logic          m_req_o;
  logic          m_gnt_i;
  logic          m_we_o;
  logic [BW-1:0] m_be_o;
  logic [AW-1:0] m_addr_o;
  logic [DW-1:0] m_wdata_o;
  logic [DW-1:0] m_rdata_i = '0;
  logic          m_rvalid_i = 1'b0;
  logic          empty_o;

  always #5 clk_i = ~clk_i;

  obi_write_buffer #(
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .s_req_i    (s_req_i),
    .s_gnt_o    (s_gnt_o),
    .s_we_i     (s_we_i),
    .s_be_i     (s_be_i),
    .s_addr_i   (s_addr_i),
    .s_wdata_i  (s_wdata_i),
    .s_rdata_o  (s_rdata_o),
    .s_rvalid_o (s_rvalid_o),
    .m_req_o    (m_req_o),
    .m_gnt_i    (m_gnt_i),
    .m_we_o     (m_we_o),
    .m_be_o     (m_be_o),
    .m_addr_o   (m_addr_o),
    .m_wdata_o  (m_wdata_o),
    .m_rdata_i  (m_rdata_i),
    .m_rvalid_i (m_rvalid_i),
    .empty_o    (empty_o)
  );

  int cyc = 0;
  always @(posedge clk_i) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s", name, what);
  endtask

  // Scoreboards: downstream {we,be,addr,wdata} and upstream responses.
  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    bit            is_rd;
  } rsp_t;

  logic [DW+AW+BW:0] exp_q[$];
  rsp_t              rsp_q[$];

  // Memory responder.
  logic [DW-1:0] mem [logic [AW-1:0]];
  bit            gnt_hold  = 1'b0;
  int            gnt_delay = 0;
  int            rsp_delay = 1;
  int            wait_cnt  = 0;
  bit            busy      = 1'b0;
  int            rsp_cnt   = 0;
  logic [DW-1:0] rsp_data  = '0;
  bit            overlap   = 1'b0;
  int            last_m_rvalid_cyc  = -1;
  int            last_rd_rvalid_cyc = -1;
  bit                acc_s = 1'b0;
  bit                req_s = 1'b0;
  logic [DW+AW+BW:0] txn_s = '0;

  assign m_gnt_i = m_req_o && !gnt_hold && !busy && (wait_cnt >= gnt_delay);

  always @(negedge clk_i) begin
    logic [DW+AW+BW:0] e;
    rsp_t r;
    acc_s = m_req_o && m_gnt_i;
    req_s = m_req_o;
    txn_s = {m_we_o, m_be_o, m_addr_o, m_wdata_o};
    if (!rst_i) begin
      if (!m_req_o) check("m_idle_zero", {m_we_o, m_be_o, m_addr_o, m_wdata_o}, '0);
      if (m_req_o && busy) overlap = 1'b1;
      if (m_rvalid_i) last_m_rvalid_cyc = cyc;
      if (acc_s) begin
        if (exp_q.size() == 0) begin
          fail("m_txn", $sformatf("unexpected downstream txn %0h, none required", txn_s));
        end else begin
          e = exp_q.pop_front();
          check("m_txn", txn_s, e);
        end
      end
      if (s_rvalid_o) begin
        if (rsp_q.size() == 0) begin
          fail("s_rvalid", $sformatf("unexpected rvalid data %0h, none required", s_rdata_o));
        end else begin
          r = rsp_q.pop_front();
          check("s_rdata", s_rdata_o, r.data);
          if (r.is_rd) begin
            check("rd_rvalid_with_m_rvalid", m_rvalid_i, 1);
            last_rd_rvalid_cyc = cyc;
          end else begin
            check("wr_rvalid_latency", cyc, r.cyc);
          end
        end
      end
    end
  end

  always @(posedge clk_i) begin
    logic [DW-1:0] old;
    logic [BW-1:0] t_be;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_wd;
    #1;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;
    if (rst_i) wait_cnt = 0;
    if (acc_s) begin
      t_be   = txn_s[DW+AW+BW-1:DW+AW];
      t_addr = txn_s[DW+AW-1:DW];
      t_wd   = txn_s[DW-1:0];
      busy     = 1'b1;
      rsp_cnt  = rsp_delay;
      wait_cnt = 0;
      if (txn_s[DW+AW+BW]) begin
        old = mem.exists(t_addr) ? mem[t_addr] : '0;
        for (int b = 0; b < BW; b++) if (t_be[b]) old[8*b +: 8] = t_wd[8*b +: 8];
        mem[t_addr] = old;
        rsp_data = '0;
      end else begin
        rsp_data = mem.exists(t_addr) ? mem[t_addr] : '0;
      end
    end else if (req_s) begin
      wait_cnt++;
    end
    if (busy) begin
      rsp_cnt--;
      if (rsp_cnt == 0) begin
        m_rvalid_i = 1'b1;
        m_rdata_i  = rsp_data;
        busy       = 1'b0;
      end
    end
  end

  // Driver: call at posedge+#1; returns at posedge+#1 after the grant edge.
  task automatic issue(input bit we, input logic [AW-1:0] addr, input logic [BW-1:0] be,
                       input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rd,
                       input int max_wait, output int gnt_cyc, output int waited);
    bit   got;
    rsp_t r;
    got = 1'b0;
    waited = 0;
    gnt_cyc = -1;
    s_req_i = 1'b1; s_we_i = we; s_be_i = be; s_addr_i = addr; s_wdata_i = wdata;
    while (!got && waited <= max_wait) begin
      @(negedge clk_i);
      if (s_gnt_o) begin
        got = 1'b1;
        gnt_cyc = cyc;
        if (we) begin
          exp_q.push_back({1'b1, be, addr, wdata});
          r.data = '0; r.cyc = cyc + 1; r.is_rd = 1'b0;
        end else begin
          exp_q.push_back({1'b0, {BW{1'b1}}, addr, {DW{1'b0}}});
          r.data = exp_rd; r.cyc = -1; r.is_rd = 1'b1;
        end
        rsp_q.push_back(r);
      end else begin
        waited++;
      end
      @(posedge clk_i); #1;
    end
    s_req_i = 1'b0; s_we_i = 1'b0; s_be_i = '0; s_addr_i = '0; s_wdata_i = '0;
    if (!got) fail("gnt_timeout", $sformatf("no grant after %0d cycles for addr %0h, required within %0d", waited, addr, max_wait));
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (!(empty_o && !busy && rsp_q.size() == 0 && exp_q.size() == 0) && n < max) begin
      @(posedge clk_i); #1;
      n++;
    end
    if (n >= max) fail("idle_timeout", $sformatf("not idle after %0d cycles, required within %0d", n, max));
    check("empty_o_idle", empty_o, 1);
  endtask

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, w, g2, w2;
    bit seen;

    vecs[0] = '{1'b1, 32'h5000, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 32'h5000, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[2] = '{1'b1, 32'h5000, 4'h0, 32'hFFFFFFFF, 32'h0};
    vecs[3] = '{1'b0, 32'h5000, 4'hF, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 32'h5000, 4'h3, 32'h11223344, 32'h0};
    vecs[5] = '{1'b0, 32'h5000, 4'hF, 32'h0,        32'hDEAD3344};
    vecs[6] = '{1'b1, 32'h5004, 4'hC, 32'hCAFEF00D, 32'h0};
    vecs[7] = '{1'b0, 32'h5004, 4'hF, 32'h0,        32'hCAFE0000};
    vecs[8] = '{1'b1, 32'h5000, 4'h8, 32'h55000000, 32'h0};
    vecs[9] = '{1'b0, 32'h5000, 4'hF, 32'h0,        32'h55AD3344};

    // Reset: outputs quiet even with a write request pending.
    s_req_i = 1'b1; s_we_i = 1'b1; s_addr_i = 32'h10; s_wdata_i = 32'h1; s_be_i = 4'hF;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_outputs", {s_gnt_o, s_rvalid_o, s_rdata_o, m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o}, '0);
    check("rst_empty", empty_o, 1);
    s_req_i = 1'b0; s_we_i = 1'b0; s_addr_i = '0; s_wdata_i = '0; s_be_i = '0;
    rst_i = 1'b0;

    // Single write, memory always granting, response one cycle later.
    gnt_delay = 0; rsp_delay = 1;
    issue(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, '0, 10, g, w);
    check("t1_gnt_same_cycle", w, 0);
    check("t1_m_req", {m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o},
          {1'b1, 1'b1, 4'hF, 32'h1000, 32'hDEADBEEF});
    check("t1_not_empty", empty_o, 0);
    wait_idle(20);

    // Burst of DEPTH+1 writes with memory grant held off.
    gnt_hold = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      issue(1'b1, 32'h1100 + 4 * i, 4'hF, 32'hA0000000 + i, '0, 5, g, w);
      check("t2_gnt_immediate", w, 0);
    end
    fork
      issue(1'b1, 32'h1100 + 4 * DEPTH, 4'hF, 32'hA0000000 + DEPTH, '0, 40, g, w);
      begin
        repeat (5) begin
          @(negedge clk_i);
          check("t2_full_stall", s_gnt_o, 0);
        end
        @(posedge clk_i); #1;
        gnt_hold = 1'b0;
      end
    join
    check("t2_stalled_long", w >= 5, 1);
    wait_idle(60);

    // Write then read of the same address; read waits for the write to drain.
    gnt_delay = 2; rsp_delay = 2;
    issue(1'b1, 32'h2000, 4'hF, 32'h11, '0, 10, g, w);
    issue(1'b0, 32'h2000, 4'hF, '0, 32'h11, 30, g2, w2);
    check("t3_rd_after_wr_drain", (g2 > last_m_rvalid_cyc) && (last_m_rvalid_cyc > g), 1);
    wait_idle(30);

    // Read with empty buffer and slow memory; a write must wait for it.
    mem[32'h3000] = 32'h5A5A1234;
    gnt_delay = 3; rsp_delay = 2;
    issue(1'b0, 32'h3000, 4'hF, '0, 32'h5A5A1234, 10, g, w);
    check("t4_rd_gnt_immediate", w, 0);
    issue(1'b1, 32'h3100, 4'hF, 32'h77, '0, 30, g2, w2);
    check("t4_wr_held_by_read", (g2 > last_rd_rvalid_cyc) && (last_rd_rvalid_cyc > g), 1);
    wait_idle(30);

    // Table-driven mixed traffic with randomised memory latency.
    for (int i = 0; i < 10; i++) begin
      gnt_delay = $urandom_range(0, 2);
      rsp_delay = $urandom_range(1, 3);
      issue(vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].exp_rdata, 40, g, w);
    end
    wait_idle(60);

    // Reset with three entries buffered and one write in flight.
    gnt_delay = 0; rsp_delay = 20;
    for (int i = 0; i < 4; i++) issue(1'b1, 32'h6000 + 4 * i, 4'hF, 32'h60 + i, '0, 10, g, w);
    check("t5_busy_before_rst", empty_o, 0);
    rst_i = 1'b1;
    s_req_i = 1'b1; s_we_i = 1'b1; s_addr_i = 32'h6100; s_be_i = 4'hF; s_wdata_i = 32'h1;
    @(negedge clk_i);
    check("t5_rst_outputs", {s_gnt_o, s_rvalid_o, s_rdata_o, m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o}, '0);
    check("t5_rst_empty", empty_o, 1);
    @(posedge clk_i); #1;
    s_req_i = 1'b0; s_we_i = 1'b0; s_addr_i = '0; s_be_i = '0; s_wdata_i = '0;
    rst_i = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    check("t5_after_rst_outputs", {s_gnt_o, s_rvalid_o, s_rdata_o, m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o}, '0);
    check("t5_after_rst_empty", empty_o, 1);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk_i);
      if (m_rvalid_i) begin
        seen = 1'b1;
        check("t5_late_rvalid_ignored", s_rvalid_o, 0);
      end
    end
    if (!seen) fail("t5_late_rvalid", "memory response never arrived, required within 30 cycles");
    @(posedge clk_i); #1;
    wait_idle(20);

    // Line-refill style back-to-back reads.
    for (int i = 0; i < 4; i++) mem[32'h4000 + 4 * i] = 32'hB0B00000 + i;
    gnt_delay = 1; rsp_delay = 2;
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, 32'h4000 + 4 * i, 4'hF, '0, 32'hB0B00000 + i, 30, g, w);
    end
    wait_idle(40);

    check("no_overlap", overlap, 0);
    check("exp_q_drained", exp_q.size(), 0);
    check("rsp_q_drained", rsp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
